// File: rtl/de_ex_pipe_stage.sv
// de_ex_pipe_stage: decode-to-execute pipeline register.
// Holds a flattened decode payload and PC, merges downstream stall requests,
// inserts bubbles on decode hazards, kills contents on flush, and stretches
// a fence request into a fence_stall window of FENCE_EXT extra cycles.
// Optional build macro DE_EX_PERF_CNT_EN adds saturating bubble/stall counters.
module de_ex_pipe_stage #(
    parameter int unsigned        DATA_W      = 256,
    parameter int unsigned        PC_W        = 32,
    parameter int unsigned        NSTALL      = 2,
    parameter logic [DATA_W-1:0]  NOP_PAYLOAD = {DATA_W{1'b0}},
    parameter int unsigned        FENCE_EXT   = 4
) (
    input  logic              clk,
    input  logic              cpurst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_payload,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [NSTALL-1:0] stall_vec,
    input  logic              de_stall,
    input  logic              flush,
    input  logic              fence_req,
    output logic              out_valid,
    output logic              out_bubble,
    output logic [DATA_W-1:0] out_payload,
    output logic [PC_W-1:0]   out_pc,
    output logic              fence_stall,
    output logic              stall
`ifdef DE_EX_PERF_CNT_EN
    ,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int unsigned      CNT_W    = $clog2(FENCE_EXT + 1);
    localparam logic [CNT_W-1:0] EXT_LOAD = CNT_W'(FENCE_EXT);

    logic              valid_q,   valid_d;
    logic              bubble_q,  bubble_d;
    logic [DATA_W-1:0] payload_q, payload_d;
    logic [PC_W-1:0]   pc_q,      pc_d;
    logic              ext_active_q, ext_active_d;
    logic [CNT_W-1:0]  ext_cnt_q,    ext_cnt_d;
    logic              bubble_load;

    assign stall       = |stall_vec;
    assign out_valid   = valid_q;
    assign out_bubble  = bubble_q;
    assign out_payload = payload_q;
    assign out_pc      = pc_q;
    assign fence_stall = fence_req | ext_active_q;

    // Stage contents: flush beats everything, then bubble, then normal load, else hold.
    always_comb begin
        valid_d     = valid_q;
        bubble_d    = bubble_q;
        payload_d   = payload_q;
        pc_d        = pc_q;
        bubble_load = 1'b0;
        if (flush || (de_stall && !stall)) begin
            bubble_load = 1'b1;
            valid_d     = 1'b0;
            bubble_d    = 1'b1;
            payload_d   = NOP_PAYLOAD;
        end else if (!stall) begin
            valid_d     = in_valid;
            bubble_d    = 1'b0;
            payload_d   = in_payload;
        end
        if (!stall) begin
            pc_d = in_pc;
        end
    end

    // Fence window: a request reloads the countdown; expiry clears the window on the last count.
    always_comb begin
        ext_active_d = ext_active_q;
        ext_cnt_d    = ext_cnt_q;
        if (fence_req) begin
            ext_active_d = 1'b1;
            ext_cnt_d    = EXT_LOAD;
        end else if (ext_active_q) begin
            ext_cnt_d = ext_cnt_q - CNT_W'(1);
            if (ext_cnt_q == CNT_W'(1)) begin
                ext_active_d = 1'b0;
            end
        end
    end

    // Stage and fence registers with asynchronous reset.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            valid_q      <= 1'b0;
            bubble_q     <= 1'b0;
            payload_q    <= NOP_PAYLOAD;
            pc_q         <= '0;
            ext_active_q <= 1'b0;
            ext_cnt_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            bubble_q     <= bubble_d;
            payload_q    <= payload_d;
            pc_q         <= pc_d;
            ext_active_q <= ext_active_d;
            ext_cnt_q    <= ext_cnt_d;
        end
    end

`ifdef DE_EX_PERF_CNT_EN
    logic [31:0] perf_bubble_q, perf_bubble_d;
    logic [31:0] perf_stall_q,  perf_stall_d;

    assign perf_bubble_cnt = perf_bubble_q;
    assign perf_stall_cnt  = perf_stall_q;

    // Saturating event counters for bubbles/flushes and stalled cycles.
    always_comb begin
        perf_bubble_d = perf_bubble_q;
        perf_stall_d  = perf_stall_q;
        if (bubble_load && (perf_bubble_q != 32'hFFFF_FFFF)) begin
            perf_bubble_d = perf_bubble_q + 32'd1;
        end
        if (stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            perf_bubble_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_bubble_q <= perf_bubble_d;
            perf_stall_q  <= perf_stall_d;
        end
    end
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_de_ex_pipe_stage.sv
// Directed testbench for de_ex_pipe_stage: reset, streaming, stall hold,
// bubble insertion, flush priority, fence window timing and async reset.
module tb_de_ex_pipe_stage;

    localparam int unsigned       DATA_W = 64;
    localparam int unsigned       PC_W   = 32;
    localparam int unsigned       NSTALL = 2;
    localparam logic [DATA_W-1:0] NOP    = 64'h0BAD_F00D_0BAD_F00D;

    logic              clk;
    logic              cpurst;
    logic              in_valid;
    logic [DATA_W-1:0] in_payload;
    logic [PC_W-1:0]   in_pc;
    logic [NSTALL-1:0] stall_vec;
    logic              de_stall;
    logic              flush;
    logic              fence_req;
    logic              out_valid;
    logic              out_bubble;
    logic [DATA_W-1:0] out_payload;
    logic [PC_W-1:0]   out_pc;
    logic              fence_stall;
    logic              stall;
`ifdef DE_EX_PERF_CNT_EN
    logic [31:0]       perf_bubble_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int exp_bub_cnt = 0;
    int exp_stl_cnt = 0;

    de_ex_pipe_stage #(
        .DATA_W      (DATA_W),
        .PC_W        (PC_W),
        .NSTALL      (NSTALL),
        .NOP_PAYLOAD (NOP),
        .FENCE_EXT   (4)
    ) dut (
        .clk         (clk),
        .cpurst      (cpurst),
        .in_valid    (in_valid),
        .in_payload  (in_payload),
        .in_pc       (in_pc),
        .stall_vec   (stall_vec),
        .de_stall    (de_stall),
        .flush       (flush),
        .fence_req   (fence_req),
        .out_valid   (out_valid),
        .out_bubble  (out_bubble),
        .out_payload (out_payload),
        .out_pc      (out_pc),
        .fence_stall (fence_stall),
        .stall       (stall)
`ifdef DE_EX_PERF_CNT_EN
        ,
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, tracking expected perf events, and settle 1 ns after it.
    task automatic tick();
        if (!cpurst) begin
            if (flush || (de_stall && (stall_vec == '0))) exp_bub_cnt++;
            if (stall_vec != '0) exp_stl_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_payload = '0;
        in_pc      = '0;
        stall_vec  = '0;
        de_stall   = 1'b0;
        flush      = 1'b0;
        fence_req  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        cpurst = 1'b1;
        #2;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        vectors++; if (out_bubble !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_bubble: got %b expected 0", out_bubble); end
        vectors++; if (out_payload !== NOP) begin miscompares++; $display("[TB] FAIL reset_payload: got %h expected %h", out_payload, NOP); end
        vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pc: got %h expected 0", out_pc); end
        vectors++; if (fence_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fence_low: got %b expected 0", fence_stall); end
        fence_req = 1'b1;
        #1;
        vectors++; if (fence_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_fence_passthru: got %b expected 1", fence_stall); end
        fence_req = 1'b0;
        tick();
        cpurst = 1'b0;
        exp_bub_cnt = 0;
        exp_stl_cnt = 0;
        #1;
        vectors++; if (fence_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fence_held: got %b expected 0", fence_stall); end
    endtask

    task automatic test_stream();
        logic [PC_W-1:0] pcs [3];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        for (int i = 0; i < 3; i++) begin
            in_valid   = 1'b1;
            in_payload = {8{8'hA5}} ^ DATA_W'(i);
            in_pc      = pcs[i];
            tick();
            vectors++; if (out_valid !== 1'b1 || out_bubble !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_flags[%0d]: got v=%b b=%b expected v=1 b=0", i, out_valid, out_bubble); end
            vectors++; if (out_pc !== pcs[i]) begin miscompares++; $display("[TB] FAIL stream_pc[%0d]: got %h expected %h", i, out_pc, pcs[i]); end
            vectors++; if (out_payload !== ({8{8'hA5}} ^ DATA_W'(i))) begin miscompares++; $display("[TB] FAIL stream_payload[%0d]: got %h", i, out_payload); end
        end
        in_valid = 1'b0;
        in_pc    = 32'h10C;
        tick();
        vectors++; if (out_valid !== 1'b0 || out_bubble !== 1'b0 || out_pc !== 32'h10C) begin miscompares++; $display("[TB] FAIL stream_invalid: got v=%b b=%b pc=%h expected v=0 b=0 pc=10c", out_valid, out_bubble, out_pc); end
    endtask

    task automatic test_stall();
        in_valid   = 1'b1;
        in_payload = 64'h0000_0000_0000_0104;
        in_pc      = 32'h104;
        tick();
        in_payload = 64'h0000_0000_0000_0108;
        in_pc      = 32'h108;
        stall_vec  = 2'b10;
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_or: got %b expected 1", stall); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (out_pc !== 32'h104 || out_payload !== 64'h104 || out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_hold[%0d]: got pc=%h pl=%h v=%b expected pc=104 pl=104 v=1", i, out_pc, out_payload, out_valid); end
        end
        stall_vec = 2'b00;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_clear: got %b expected 0", stall); end
        tick();
        vectors++; if (out_pc !== 32'h108 || out_payload !== 64'h108) begin miscompares++; $display("[TB] FAIL stall_release: got pc=%h pl=%h expected pc=108 pl=108", out_pc, out_payload); end
    endtask

    task automatic test_bubble();
        in_valid   = 1'b1;
        in_payload = 64'h1111_2222_3333_4444;
        in_pc      = 32'h200;
        de_stall   = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b0 || out_bubble !== 1'b1) begin miscompares++; $display("[TB] FAIL bubble_flags: got v=%b b=%b expected v=0 b=1", out_valid, out_bubble); end
        vectors++; if (out_payload !== NOP || out_pc !== 32'h200) begin miscompares++; $display("[TB] FAIL bubble_data: got pl=%h pc=%h expected pl=%h pc=200", out_payload, out_pc, NOP); end
        de_stall   = 1'b0;
        in_payload = 64'hCAFE_0000_0000_0204;
        in_pc      = 32'h204;
        tick();
        de_stall   = 1'b1;
        stall_vec  = 2'b01;
        in_payload = 64'hCAFE_0000_0000_0208;
        in_pc      = 32'h208;
        tick();
        vectors++; if (out_valid !== 1'b1 || out_bubble !== 1'b0 || out_payload !== 64'hCAFE_0000_0000_0204 || out_pc !== 32'h204) begin miscompares++; $display("[TB] FAIL bubble_held: got v=%b b=%b pl=%h pc=%h expected v=1 b=0 pl=cafe000000000204 pc=204", out_valid, out_bubble, out_payload, out_pc); end
        de_stall = 1'b0;
    endtask

    task automatic test_flush();
        stall_vec = 2'b11;
        flush     = 1'b1;
        in_pc     = 32'h300;
        tick();
        vectors++; if (out_valid !== 1'b0 || out_bubble !== 1'b1 || out_payload !== NOP) begin miscompares++; $display("[TB] FAIL flush_stalled: got v=%b b=%b pl=%h expected v=0 b=1 pl=%h", out_valid, out_bubble, out_payload, NOP); end
        vectors++; if (out_pc !== 32'h204) begin miscompares++; $display("[TB] FAIL flush_pc_hold: got %h expected 204", out_pc); end
        stall_vec = 2'b00;
        in_pc     = 32'h500;
        tick();
        vectors++; if (out_pc !== 32'h500 || out_bubble !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_pc_update: got pc=%h b=%b expected pc=500 b=1", out_pc, out_bubble); end
        flush      = 1'b0;
        in_valid   = 1'b1;
        in_payload = 64'h5555_0000_0000_0504;
        in_pc      = 32'h504;
        tick();
        vectors++; if (out_valid !== 1'b1 || out_bubble !== 1'b0 || out_payload !== 64'h5555_0000_0000_0504) begin miscompares++; $display("[TB] FAIL flush_recover: got v=%b b=%b pl=%h expected v=1 b=0", out_valid, out_bubble, out_payload); end
    endtask

    task automatic test_fence();
        fence_req = 1'b1;
        #1;
        vectors++; if (fence_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL fence_comb: got %b expected 1", fence_stall); end
        tick();
        fence_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (fence_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL fence_ext[%0d]: got %b expected 1", i, fence_stall); end
            tick();
        end
        vectors++; if (fence_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL fence_expire: got %b expected 0", fence_stall); end
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        tick();
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (fence_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL fence_retrig[%0d]: got %b expected 1", i, fence_stall); end
            tick();
        end
        vectors++; if (fence_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL fence_retrig_expire: got %b expected 0", fence_stall); end
    endtask

`ifdef DE_EX_PERF_CNT_EN
    task automatic test_perf();
        vectors++; if (perf_bubble_cnt !== 32'(exp_bub_cnt)) begin miscompares++; $display("[TB] FAIL perf_bubble: got %0d expected %0d", perf_bubble_cnt, exp_bub_cnt); end
        vectors++; if (perf_stall_cnt !== 32'(exp_stl_cnt)) begin miscompares++; $display("[TB] FAIL perf_stall: got %0d expected %0d", perf_stall_cnt, exp_stl_cnt); end
    endtask
`endif

    task automatic test_async_reset();
        in_valid   = 1'b1;
        in_payload = 64'h7777_0000_0000_0600;
        in_pc      = 32'h600;
        fence_req  = 1'b1;
        tick();
        fence_req = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b1 || fence_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_pre: got v=%b fs=%b expected v=1 fs=1", out_valid, fence_stall); end
        #2;
        cpurst = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || fence_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_clear: got v=%b pc=%h fs=%b expected v=0 pc=0 fs=0", out_valid, out_pc, fence_stall); end
        vectors++; if (out_payload !== NOP || out_bubble !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_payload: got pl=%h b=%b expected pl=%h b=0", out_payload, out_bubble, NOP); end
`ifdef DE_EX_PERF_CNT_EN
        vectors++; if (perf_bubble_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin miscompares++; $display("[TB] FAIL areset_perf: got b=%0d s=%0d expected 0 0", perf_bubble_cnt, perf_stall_cnt); end
`endif
        tick();
        cpurst = 1'b0;
        exp_bub_cnt = 0;
        exp_stl_cnt = 0;
        in_pc      = 32'h700;
        in_payload = 64'h7777_0000_0000_0700;
        tick();
        vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h700 || fence_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_first_edge: got v=%b pc=%h fs=%b expected v=1 pc=700 fs=0", out_valid, out_pc, fence_stall); end
    endtask

    // Run all scenarios in order, then report.
    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_bubble();
        test_flush();
`ifdef DE_EX_PERF_CNT_EN
        test_perf();
`endif
        test_fence();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
